// File: rtl/vip_uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART VIP transmitter between byte requesters.
// Optional line locking keeps a grant until end-of-line or an idle timeout.
module vip_uart_tx_arbiter #(
    parameter int         nreq         = 2,
    parameter bit         lock_on_line = 1'b1,
    parameter int         lock_timeout = 1024,
    parameter logic [7:0] eol          = 8'h0A
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [nreq-1:0]   i_req,
    input  logic [8*nreq-1:0] i_wdata,
    output logic [nreq-1:0]   o_ack,
    output logic [nreq-1:0]   o_grant,
    output logic              o_busy,
    output logic              o_tx_we,
    output logic [7:0]        o_tx_wdata,
    input  logic              i_tx_full
);

    localparam int OW = $clog2(nreq);
    localparam int CW = $clog2(lock_timeout + 1);
    localparam logic [CW-1:0] CNT_LIM = CW'(lock_timeout - 1);

    typedef enum logic {
        S_IDLE,
        S_XFER
    } state_t;

    state_t        r_state;
    state_t        w_state_nx;
    logic [OW-1:0] r_owner;
    logic [OW-1:0] w_owner_nx;
    logic [OW-1:0] r_rr_last;
    logic [OW-1:0] w_rr_last_nx;
    logic [CW-1:0] r_idle_cnt;
    logic [CW-1:0] w_idle_cnt_nx;

    logic            w_found;
    logic [OW-1:0]   w_pick;
    logic [nreq-1:0] w_own_oh;
    logic            w_req_own;
    logic [7:0]      w_byte_own;
    logic            w_busy;
    logic            w_write;

    function automatic int wrap_idx(input int v);
        return (v >= nreq) ? v - nreq : v;
    endfunction

    // Circular scan for the next requester, starting just after the last owner
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        for (int i = 1; i <= nreq; i++) begin
            for (int k = 0; k < nreq; k++) begin
                if (!w_found && (k == wrap_idx(int'(r_rr_last) + i)) && i_req[k]) begin
                    w_found = 1'b1;
                    w_pick  = OW'(k);
                end
            end
        end
    end

    // Select the current owner's request, byte and one-hot flag
    always_comb begin
        w_own_oh   = '0;
        w_req_own  = 1'b0;
        w_byte_own = 8'h00;
        for (int k = 0; k < nreq; k++) begin
            if (r_owner == OW'(k)) begin
                w_own_oh[k] = 1'b1;
                w_req_own   = i_req[k];
                w_byte_own  = i_wdata[8*k +: 8];
            end
        end
    end

    assign w_busy  = (r_state == S_XFER);
    assign w_write = w_busy & w_req_own & ~i_tx_full;

    assign o_busy     = w_busy;
    assign o_grant    = w_busy ? w_own_oh : '0;
    assign o_ack      = w_write ? w_own_oh : '0;
    assign o_tx_we    = w_write;
    assign o_tx_wdata = w_write ? w_byte_own : 8'h00;

    // Next-state: grant from IDLE, release on byte/eol/timeout in XFER
    always_comb begin
        w_state_nx    = r_state;
        w_owner_nx    = r_owner;
        w_rr_last_nx  = r_rr_last;
        w_idle_cnt_nx = r_idle_cnt;
        unique case (r_state)
            S_IDLE: begin
                w_idle_cnt_nx = '0;
                if (w_found) begin
                    w_state_nx = S_XFER;
                    w_owner_nx = w_pick;
                end
            end
            S_XFER: begin
                if (w_write) begin
                    w_idle_cnt_nx = '0;
                    if (!lock_on_line || (w_byte_own == eol)) begin
                        w_state_nx   = S_IDLE;
                        w_rr_last_nx = r_owner;
                    end
                end else if (lock_on_line) begin
                    if (r_idle_cnt >= CNT_LIM) begin
                        w_state_nx    = S_IDLE;
                        w_rr_last_nx  = r_owner;
                        w_idle_cnt_nx = '0;
                    end else begin
                        w_idle_cnt_nx = r_idle_cnt + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    // State registers; reset drops any grant immediately
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_owner    <= '0;
            r_rr_last  <= OW'(nreq - 1);
            r_idle_cnt <= '0;
        end else begin
            r_state    <= w_state_nx;
            r_owner    <= w_owner_nx;
            r_rr_last  <= w_rr_last_nx;
            r_idle_cnt <= w_idle_cnt_nx;
        end
    end

endmodule

// File: tb/tb_vip_uart_tx_arbiter.sv
// Scoreboard bench for vip_uart_tx_arbiter: one locked-line instance
// (timeout 16) and one per-byte-release instance, directed vectors.
module tb_vip_uart_tx_arbiter;

    logic        clk;
    logic        rst;
    logic [1:0]  req   [2];
    logic [15:0] wd    [2];
    logic        full  [2];
    logic [1:0]  ack   [2];
    logic [1:0]  grant [2];
    logic        busy  [2];
    logic        we    [2];
    logic [7:0]  txd   [2];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [9:0] exp0 [$];
    logic [9:0] exp1 [$];
    int         wr_cyc [$];

    event ev_a;

    vip_uart_tx_arbiter #(
        .nreq(2), .lock_on_line(1'b1), .lock_timeout(16), .eol(8'h0A)
    ) u_ll (
        .i_clk(clk), .i_rst(rst), .i_req(req[0]), .i_wdata(wd[0]),
        .o_ack(ack[0]), .o_grant(grant[0]), .o_busy(busy[0]),
        .o_tx_we(we[0]), .o_tx_wdata(txd[0]), .i_tx_full(full[0])
    );

    vip_uart_tx_arbiter #(
        .nreq(2), .lock_on_line(1'b0), .lock_timeout(16), .eol(8'h0A)
    ) u_nl (
        .i_clk(clk), .i_rst(rst), .i_req(req[1]), .i_wdata(wd[1]),
        .o_ack(ack[1]), .o_grant(grant[1]), .o_busy(busy[1]),
        .o_tx_we(we[1]), .o_tx_wdata(txd[1]), .i_tx_full(full[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, got, exp);
        end
    endtask

    // Monitor one DUT: pop the scoreboard on every write
    task automatic mon(input int d);
        logic [9:0] e;
        checks++;
        if (!$onehot0(ack[d]) || !$onehot0(grant[d])) begin
            errors++;
            $display("FAIL onehot dut%0d: ack %b grant %b", d, ack[d], grant[d]);
        end
        if (we[d]) begin
            if (full[d]) begin
                errors++;
                $display("FAIL write_while_full dut%0d: we 1 expected 0", d);
            end
            if (d == 1) wr_cyc.push_back(cyc);
            if ((d == 0 && exp0.size() == 0) || (d == 1 && exp1.size() == 0)) begin
                errors++;
                $display("FAIL unexpected_write dut%0d: ack %b data %h expected none", d, ack[d], txd[d]);
            end else begin
                e = (d == 0) ? exp0.pop_front() : exp1.pop_front();
                checks++;
                if ({ack[d], txd[d]} !== e) begin
                    errors++;
                    $display("FAIL sb_write dut%0d: ack %b data %h expected ack %b data %h",
                             d, ack[d], txd[d], e[9:8], e[7:0]);
                end
            end
        end else if (ack[d] != 2'b00 || txd[d] != 8'h00) begin
            errors++;
            $display("FAIL idle_outputs dut%0d: ack %b data %h expected 0", d, ack[d], txd[d]);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            mon(0);
            mon(1);
        end
    end

    // Present one byte and hold it until acked; waited = negedges seen
    task automatic send(input int d, input int k, input logic [7:0] b, output int waited);
        req[d][k] = 1'b1;
        wd[d][8*k +: 8] = b;
        waited = 0;
        while (waited < 200) begin
            @(negedge clk);
            waited++;
            if (ack[d][k]) break;
        end
        if (!ack[d][k]) begin
            errors++;
            $display("FAIL ack_timeout dut%0d req%0d: no ack expected ack", d, k);
        end
        @(posedge clk);
        #1;
        req[d][k] = 1'b0;
    endtask

    // Count cycles the locked instance keeps req0 granted without writing
    task automatic count_hold(output int n);
        n = 0;
        @(negedge clk);
        while (grant[0] == 2'b01 && n < 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic chk_zero(input string n);
        chk({n, "_grant"}, 32'(grant[0]), 0);
        chk({n, "_busy"},  32'(busy[0]),  0);
        chk({n, "_we"},    32'(we[0]),    0);
        chk({n, "_ack"},   32'(ack[0]),   0);
        chk({n, "_wdata"}, 32'(txd[0]),   0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int wa, wb, wc, wx, n;
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            req[d] = '0;
            wd[d] = '0;
            full[d] = 1'b0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_zero("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // First grant and write latency
        @(posedge clk);
        #1;
        exp0.push_back({2'b01, 8'h41});
        req[0][0] = 1'b1;
        wd[0][7:0] = 8'h41;
        @(negedge clk);
        chk("t1_idle_grant", 32'(grant[0]), 0);
        chk("t1_idle_we", 32'(we[0]), 0);
        @(negedge clk);
        chk("t1_grant", 32'(grant[0]), 32'h1);
        chk("t1_we", 32'(we[0]), 1);
        chk("t1_wdata", 32'(txd[0]), 32'h41);
        @(posedge clk);
        #1;
        req[0][0] = 1'b0;
        exp0.push_back({2'b01, 8'h0A});
        send(0, 0, 8'h0A, wa);
        chk("t1_locked_eol_lat", wa, 1);

        // Per-byte release alternates with one bubble
        exp1.push_back({2'b01, 8'h10});
        exp1.push_back({2'b10, 8'h20});
        exp1.push_back({2'b01, 8'h11});
        exp1.push_back({2'b10, 8'h21});
        exp1.push_back({2'b01, 8'h12});
        exp1.push_back({2'b10, 8'h22});
        wr_cyc.delete();
        fork
            begin
                send(1, 0, 8'h10, wa);
                send(1, 0, 8'h11, wa);
                send(1, 0, 8'h12, wa);
            end
            begin
                send(1, 1, 8'h20, wb);
                send(1, 1, 8'h21, wb);
                send(1, 1, 8'h22, wb);
            end
        join
        chk("t2_nwrites", wr_cyc.size(), 6);
        for (int i = 1; i < wr_cyc.size(); i++)
            chk("t2_gap", wr_cyc[i] - wr_cyc[i-1], 2);

        // Locked line blocks the other requester until eol
        exp0.push_back({2'b01, 8'h41});
        exp0.push_back({2'b01, 8'h42});
        exp0.push_back({2'b01, 8'h0A});
        exp0.push_back({2'b10, 8'h58});
        fork
            begin
                send(0, 0, 8'h41, wa);
                ->ev_a;
                send(0, 0, 8'h42, wa);
                send(0, 0, 8'h0A, wa);
            end
            begin
                @ev_a;
                send(0, 1, 8'h58, wb);
            end
        join
        chk("t3_req1_wait", wb, 4);
        exp0.push_back({2'b10, 8'h0A});
        send(0, 1, 8'h0A, wa);
        chk("t3_req1_eol_lat", wa, 1);

        // Idle timeout hands the grant to the waiting requester
        exp0.push_back({2'b01, 8'h41});
        exp0.push_back({2'b10, 8'h0A});
        fork
            begin
                send(0, 0, 8'h41, wa);
                count_hold(n);
                chk("t4_hold_cycles", n, 16);
                chk("t4_bubble_grant", 32'(grant[0]), 0);
            end
            send(0, 1, 8'h0A, wb);
        join
        chk("t4_req0_lat", wa, 2);
        chk("t4_req1_wait", wb, 20);

        // Full stall inside a locked line, then a fresh timeout
        exp0.push_back({2'b01, 8'h43});
        send(0, 0, 8'h43, wa);
        chk("t5_first_lat", wa, 2);
        exp0.push_back({2'b01, 8'h44});
        fork
            send(0, 0, 8'h44, wa);
            begin
                full[0] = 1'b1;
                repeat (5) @(posedge clk);
                #1;
                full[0] = 1'b0;
            end
        join
        chk("t5_stall_wait", wa, 6);
        count_hold(n);
        chk("t5_hold_cycles", n, 16);

        // Reset mid-line with a pending byte
        @(posedge clk);
        #1;
        exp0.push_back({2'b01, 8'h45});
        send(0, 0, 8'h45, wa);
        full[0] = 1'b1;
        exp0.push_back({2'b01, 8'h46});
        exp0.push_back({2'b01, 8'h0A});
        exp0.push_back({2'b10, 8'h31});
        exp0.push_back({2'b10, 8'h0A});
        fork
            begin
                send(0, 0, 8'h46, wa);
                send(0, 0, 8'h0A, wc);
            end
            begin
                send(0, 1, 8'h31, wb);
                send(0, 1, 8'h0A, wx);
            end
            begin
                repeat (3) @(posedge clk);
                #2;
                chk("t6_pre_grant", 32'(grant[0]), 32'h1);
                #1;
                rst = 1'b1;
                #1;
                chk_zero("t6_async");
                repeat (2) @(posedge clk);
                #1;
                rst = 1'b0;
                full[0] = 1'b0;
            end
        join

        repeat (3) @(negedge clk);
        chk("sb0_empty", exp0.size(), 0);
        chk("sb1_empty", exp1.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
